// File: rtl/crack_pkg.sv
// Shared types and helpers for the brute-force password search engine:
// FSM state encoding, alphabet index to ASCII mapping and worker keyspace slicing.
package crack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Alphabet index 0..25 -> 'a'..'z', 26..35 -> '0'..'9'.
  function automatic logic [7:0] idx_to_ascii(input int unsigned idx);
    if (idx < 32'd26) return 8'(idx + 32'd97);
    return 8'(idx + 32'd22);
  endfunction

  // First-character slice owned by worker w; slices are disjoint and cover the alphabet.
  function automatic int lo(input int w, input int num_workers, input int charset);
    return (w * charset) / num_workers;
  endfunction

  function automatic int hi(input int w, input int num_workers, input int charset);
    return ((w + 1) * charset) / num_workers - 1;
  endfunction

endpackage

// File: rtl/crack_worker.sv
// One candidate generator: a PW_LEN-digit base-CHARSET odometer sweeping first
// digits LO..HI, compared against the latched target every active RUN cycle.
module crack_worker
  import crack_pkg::*;
#(
  parameter int PW_LEN  = 4,
  parameter int CHARSET = 36,
  parameter int LO      = 0,
  parameter int HI      = 35
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic [8*PW_LEN-1:0] target,
  output logic                match,
  output logic [8*PW_LEN-1:0] candidate,
  output logic                exhausted
);

  localparam int DIG_W = (CHARSET > 1) ? $clog2(CHARSET) : 1;
  localparam logic [DIG_W-1:0] MAX_D = DIG_W'(CHARSET - 1);
  localparam logic [DIG_W-1:0] LO_D  = DIG_W'(LO);
  localparam logic [DIG_W-1:0] HI_D  = DIG_W'(HI);

  // digit[0] is the leftmost character.
  logic [DIG_W-1:0] digit      [PW_LEN];
  logic [DIG_W-1:0] next_digit [PW_LEN];
  logic             last;

  // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin : odometer
    logic carry;
    carry = 1'b1;
    last  = (digit[0] == HI_D);
    for (int i = PW_LEN - 1; i >= 0; i--) begin
      next_digit[i] = digit[i];
      if (i > 0 && digit[i] != MAX_D) last = 1'b0;
      if (carry) begin
        if (digit[i] == MAX_D) begin
          next_digit[i] = '0;
        end else begin
          next_digit[i] = digit[i] + 1'b1;
          carry         = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PW_LEN; i++) digit[i] <= '0;
      exhausted <= 1'b0;
    end else if (load) begin
      digit[0] <= LO_D;
      for (int i = 1; i < PW_LEN; i++) digit[i] <= '0;
      exhausted <= 1'b0;
    end else if (run && !exhausted) begin
      if (last) begin
        exhausted <= 1'b1;
      end else begin
        for (int i = 0; i < PW_LEN; i++) digit[i] <= next_digit[i];
      end
    end
  end

  always_comb begin
    candidate = '0;
    for (int i = 0; i < PW_LEN; i++) begin
      candidate[8*(PW_LEN-1-i) +: 8] = idx_to_ascii(32'(digit[i]));
    end
  end

  assign match = run && !exhausted && (candidate == target);

endmodule

// File: rtl/crack_array_ctrl.sv
// Parametrised password search controller: NUM_WORKERS parallel generators,
// start/busy/done handshake with early abort on the first match.
module crack_array_ctrl
  import crack_pkg::*;
#(
  parameter int NUM_WORKERS = 9,
  parameter int PW_LEN      = 4,
  parameter int CHARSET     = 36,
  parameter int CNT_W       = 32,
  localparam int RW_W       = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*PW_LEN-1:0] target,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [8*PW_LEN-1:0] result,
  output logic [RW_W-1:0]     result_worker,
  output logic [CNT_W-1:0]    cycles
);

  if (NUM_WORKERS < 1 || NUM_WORKERS > CHARSET) begin : g_bad_cfg
    $error("crack_array_ctrl: NUM_WORKERS must be within 1..CHARSET");
  end

  state_t state, state_next;
  logic   accept, capture;

  logic [8*PW_LEN-1:0] target_q;
  logic [NUM_WORKERS-1:0] match_vec, exh_vec;
  logic [8*PW_LEN-1:0] cand [NUM_WORKERS];

  logic                any_match, all_exhausted;
  logic [RW_W-1:0]     hit_idx;
  logic [8*PW_LEN-1:0] hit_cand;

  for (genvar w = 0; w < NUM_WORKERS; w++) begin : g_worker
    crack_worker #(
      .PW_LEN (PW_LEN),
      .CHARSET(CHARSET),
      .LO     (lo(w, NUM_WORKERS, CHARSET)),
      .HI     (hi(w, NUM_WORKERS, CHARSET))
    ) u_worker (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .run      (state == ST_RUN),
      .target   (target_q),
      .match    (match_vec[w]),
      .candidate(cand[w]),
      .exhausted(exh_vec[w])
    );
  end

  assign any_match     = |match_vec;
  assign all_exhausted = &exh_vec;

  // Slices are disjoint, so at most one bit of match_vec is ever set.
  always_comb begin
    hit_idx  = '0;
    hit_cand = '0;
    for (int w = 0; w < NUM_WORKERS; w++) begin
      if (match_vec[w]) begin
        hit_idx  = RW_W'(w);
        hit_cand = cand[w];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (any_match) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else if (all_exhausted) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The drain cycle after the last worker exhausts is not a search cycle and is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q      <= '0;
      found         <= 1'b0;
      result        <= '0;
      result_worker <= '0;
      cycles        <= '0;
    end else if (accept) begin
      target_q      <= target;
      found         <= 1'b0;
      result        <= '0;
      result_worker <= '0;
      cycles        <= '0;
    end else if (state == ST_RUN) begin
      if (!all_exhausted && cycles != {CNT_W{1'b1}}) cycles <= cycles + 1'b1;
      if (capture) begin
        found         <= 1'b1;
        result        <= hit_cand;
        result_worker <= hit_idx;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
